iic_init_seq: RTL and testbench
===============================

// Module: iic_init_seq
// PURPOSE
//   Parametrised register-initialisation sequencer for IIC-configured sensors/decoders.
//   After a power-up delay, walks an init table in synchronous ROM and issues one write per entry to the IIC master.
//   Handshakes with the master, retries NACKed writes, honours in-table delay/end markers and can be re-triggered.
//   Sits between the init ROM and the IIC master, replacing free-running timed writes.
// PARAMETERS
//   ROM_AW       7        ROM address width
//   NUM_ENTRIES  120      entries walked if no END_TAG (1..2**ROM_AW)
//   AB_W         8        register address width
//   DB_W         8        register data width (ROM word = AB_W+DB_W, addr in MSBs)
//   PWRUP_CYC    1000000  cycles waited after reset/start before first fetch (20 ms @ 50 MHz)
//   GAP_CYC      30000    idle cycles between consecutive writes
//   ACK_TO_CYC   200000   cycles to wait for iic_done before declaring timeout
//   MAX_RETRY    3        re-issues of a failed write before aborting
//   DELAY_TAG    8'hFF    entry address meaning "wait db*GAP_CYC cycles, no write"
//   END_TAG      8'hFE    entry address meaning "table ends here"
// PORTS
//   clk          in   1            system clock
//   rst          in   1            asynchronous active-high reset
//   start        in   1            1-cycle pulse: re-run full sequence (incl. power-up delay)
//   rom_addr     out  ROM_AW       ROM address, registered
//   rom_data     in   AB_W+DB_W    ROM word, valid 1 cycle after rom_addr changes
//   tiic_en      out  1            1-cycle write request to IIC master
//   tiic_ab      out  AB_W         register address, stable from tiic_en until iic_done
//   tiic_db      out  DB_W         register data, same stability as tiic_ab
//   iic_done     in   1            1-cycle pulse: master finished current write
//   iic_nack     in   1            sampled with iic_done: 1 = write failed
//   busy         out  1            high from leaving IDLE until DONE/ERR
//   init_done    out  1            level: table completed without abort
//   init_err     out  1            level: aborted (retries exhausted or timeout)
//   err_idx      out  ROM_AW       entry index of abort
// BEHAVIOUR
//   Reset (async): state=PWRUP, all counters 0, rom_addr=0, tiic_en=0, tiic_ab/db=0,
//     busy=1, init_done=0, init_err=0, err_idx=0. Sequence starts automatically on reset release.
//   States: IDLE, PWRUP, FETCH, DECODE, REQ, WAIT, GAP, DLY, DONE, ERR.
//   PWRUP: count PWRUP_CYC cycles, then rom_addr<=0 -> FETCH.
//   FETCH: one wait cycle for ROM latency -> DECODE.
//   DECODE: ab=rom_data[MSBs]. ab==END_TAG -> DONE; ab==DELAY_TAG -> DLY (db==0 acts as 1);
//     else latch tiic_ab/tiic_db, retry=0 -> REQ.
//   REQ: tiic_en=1 for exactly this cycle -> WAIT; timeout counter cleared.
//   WAIT: iic_done&!iic_nack -> GAP. iic_done&iic_nack or ACK_TO_CYC elapsed:
//     retry<MAX_RETRY -> retry+1, REQ (after GAP_CYC via GAP, same entry); else ERR.
//     iic_done in same cycle as timeout expiry counts as done.
//   GAP/DLY: count GAP_CYC (DLY: db*GAP_CYC); then advance index.
//   Advance: index==NUM_ENTRIES-1 -> DONE; else rom_addr+1 -> FETCH. No wrap past NUM_ENTRIES-1.
//   DONE: init_done=1, busy=0, outputs hold. ERR: init_err=1, busy=0, err_idx=index.
//   start: honoured in any state; clears init_done/init_err/counters, tiic_en forced 0, -> PWRUP.
//     start during WAIT abandons the write; a later iic_done is ignored (only WAIT consumes it).
//   iic_done outside WAIT ignored. tiic_en never asserted twice without an intervening iic_done/timeout.
//   Delay counters sized for max(PWRUP_CYC, 255*GAP_CYC, ACK_TO_CYC); no overflow allowed.
// TESTING (bench params: PWRUP_CYC=10, GAP_CYC=4, ACK_TO_CYC=20, MAX_RETRY=2, NUM_ENTRIES=4)
//   Reset release, ROM {1214,1101,2280,3344}, master acks after 3 cycles -> 4 tiic_en pulses,
//     ab/db = 12/14,11/01,22/80,33/44 in order; first pulse 12 cycles after reset; init_done=1.
//   Entry1 = FF03 -> no write for entry1, 12-cycle pause, writes resume at entry2.
//   Entry2 = FE00 -> exactly 2 writes, init_done=1, rom_addr stops at 2.
//   Entry1 NACKed twice then acked -> 3 pulses with ab=11, db=01; init_done=1, init_err=0.
//   Entry1 always NACKed -> 3 pulses for entry1, init_err=1, err_idx=1, busy=0; no iic_done -> same after 20-cycle timeouts.
//   start pulsed mid-WAIT and rst pulsed mid-GAP -> tiic_en low, sequence restarts from entry0 after PWRUP.

Source files
------------

// File: rtl/iic_init_seq_if.sv
// Bus between the init sequencer, its init ROM and the IIC master.
// "master" is the sequencer side; "slave" is the ROM plus IIC master side.
interface iic_init_seq_if #(
    parameter int ROM_AW = 7,
    parameter int AB_W   = 8,
    parameter int DB_W   = 8
);
    logic [ROM_AW-1:0]    rom_addr;
    logic [AB_W+DB_W-1:0] rom_data;
    logic                 tiic_en;
    logic [AB_W-1:0]      tiic_ab;
    logic [DB_W-1:0]      tiic_db;
    logic                 iic_done;
    logic                 iic_nack;

    modport master (
        output rom_addr, tiic_en, tiic_ab, tiic_db,
        input  rom_data, iic_done, iic_nack
    );

    modport slave (
        input  rom_addr, tiic_en, tiic_ab, tiic_db,
        output rom_data, iic_done, iic_nack
    );
endinterface

// File: rtl/iic_init_seq.sv
// Register-initialisation sequencer: walks an init table held in ROM and issues one IIC write
// per entry, with retries, in-table delay/end markers, a power-up delay and restart on start.
module iic_init_seq #(
    parameter int              ROM_AW      = 7,
    parameter int              NUM_ENTRIES = 120,
    parameter int              AB_W        = 8,
    parameter int              DB_W        = 8,
    parameter int              PWRUP_CYC   = 1000000,
    parameter int              GAP_CYC     = 30000,
    parameter int              ACK_TO_CYC  = 200000,
    parameter int              MAX_RETRY   = 3,
    parameter logic [AB_W-1:0] DELAY_TAG   = AB_W'(8'hFF),
    parameter logic [AB_W-1:0] END_TAG     = AB_W'(8'hFE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    iic_init_seq_if.master    bus,
    output logic              busy,
    output logic              init_done,
    output logic              init_err,
    output logic [ROM_AW-1:0] err_idx
);

    // One shared delay counter must cover the longest wait of any counting state.
    localparam int DLY_MAX = ((2 ** DB_W) - 1) * GAP_CYC;
    localparam int MAX_A   = (PWRUP_CYC > DLY_MAX) ? PWRUP_CYC : DLY_MAX;
    localparam int CNT_MAX = (MAX_A > ACK_TO_CYC) ? MAX_A : ACK_TO_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        IDLE, PWRUP, FETCH, DECODE, REQ, WAIT, GAP, DLY, DONE, ERR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_lim;
    logic [CNT_W-1:0]   dly_lim;
    logic [RETRY_W-1:0] retry;
    logic               retry_pend;
    logic [AB_W-1:0]    rom_ab;
    logic [DB_W-1:0]    rom_db;
    logic [DB_W-1:0]    dly_mult;
    logic               cnt_hit;
    logic               counting;
    logic               last_entry;
    logic               can_retry;
    logic               wait_ok;
    logic               wait_fail;

    assign rom_ab     = bus.rom_data[AB_W+DB_W-1 -: AB_W];
    assign rom_db     = bus.rom_data[DB_W-1:0];
    assign dly_mult   = (rom_db == '0) ? DB_W'(1) : rom_db;
    assign last_entry = (bus.rom_addr == ROM_AW'(NUM_ENTRIES - 1));
    assign can_retry  = (retry < RETRY_W'(MAX_RETRY));
    assign counting   = (state == PWRUP) || (state == WAIT) || (state == GAP) || (state == DLY);
    assign cnt_hit    = (cnt == cnt_lim);
    // A done arriving on the very cycle the timeout expires still counts as a response.
    assign wait_ok    = (state == WAIT) && bus.iic_done && !bus.iic_nack;
    assign wait_fail  = (state == WAIT) && (bus.iic_done ? bus.iic_nack : cnt_hit);

    always_comb begin
        cnt_lim = '0;
        case (state)
            PWRUP:   cnt_lim = CNT_W'(PWRUP_CYC - 1);
            WAIT:    cnt_lim = CNT_W'(ACK_TO_CYC - 1);
            GAP:     cnt_lim = CNT_W'(GAP_CYC - 1);
            DLY:     cnt_lim = dly_lim - CNT_W'(1);
            default: cnt_lim = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PWRUP;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = PWRUP;
        end else begin
            case (state)
                IDLE:   state_next = IDLE;
                PWRUP:  if (cnt_hit) state_next = FETCH;
                FETCH:  state_next = DECODE;
                DECODE: begin
                    if (rom_ab == END_TAG)        state_next = DONE;
                    else if (rom_ab == DELAY_TAG) state_next = DLY;
                    else                          state_next = REQ;
                end
                REQ:    state_next = WAIT;
                WAIT: begin
                    if (wait_ok)        state_next = GAP;
                    else if (wait_fail) state_next = can_retry ? GAP : ERR;
                end
                // A pending retry re-issues the same entry instead of advancing.
                GAP: begin
                    if (cnt_hit) begin
                        if (retry_pend)      state_next = REQ;
                        else if (last_entry) state_next = DONE;
                        else                 state_next = FETCH;
                    end
                end
                DLY:    if (cnt_hit) state_next = last_entry ? DONE : FETCH;
                DONE:   state_next = DONE;
                ERR:    state_next = ERR;
                default: state_next = PWRUP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            dly_lim      <= '0;
            retry        <= '0;
            retry_pend   <= 1'b0;
            err_idx      <= '0;
            bus.rom_addr <= '0;
            bus.tiic_ab  <= '0;
            bus.tiic_db  <= '0;
        end else if (start) begin
            cnt          <= '0;
            retry        <= '0;
            retry_pend   <= 1'b0;
            bus.rom_addr <= '0;
        end else begin
            if (counting && (state_next == state)) cnt <= cnt + CNT_W'(1);
            else                                   cnt <= '0;
            case (state)
                PWRUP: if (cnt_hit) bus.rom_addr <= '0;
                DECODE: begin
                    if (rom_ab == DELAY_TAG) begin
                        dly_lim <= CNT_W'(dly_mult) * CNT_W'(GAP_CYC);
                    end else if (rom_ab != END_TAG) begin
                        bus.tiic_ab <= rom_ab;
                        bus.tiic_db <= rom_db;
                        retry       <= '0;
                    end
                end
                WAIT: begin
                    if (wait_fail) begin
                        if (can_retry) begin
                            retry      <= retry + RETRY_W'(1);
                            retry_pend <= 1'b1;
                        end else begin
                            err_idx    <= bus.rom_addr;
                        end
                    end
                end
                GAP: begin
                    if (cnt_hit) begin
                        retry_pend <= 1'b0;
                        if (state_next == FETCH) bus.rom_addr <= bus.rom_addr + ROM_AW'(1);
                    end
                end
                DLY: if (cnt_hit && (state_next == FETCH)) bus.rom_addr <= bus.rom_addr + ROM_AW'(1);
                default: ;
            endcase
        end
    end

    // A start arriving during REQ suppresses the request so the master never sees an orphan write.
    always_comb begin
        bus.tiic_en = (state == REQ) && !start;
        busy        = (state != IDLE) && (state != DONE) && (state != ERR);
        init_done   = (state == DONE);
        init_err    = (state == ERR);
    end

endmodule

// File: tb/tb_iic_init_seq.sv
// Self-checking bench for iic_init_seq: an entry-level timeline model predicts every write pulse
// and the final status, and each cycle the DUT is compared against it.
module tb_iic_init_seq;

    localparam int ROM_AW      = 7;
    localparam int NUM_ENTRIES = 4;
    localparam int PWRUP_CYC   = 10;
    localparam int GAP_CYC     = 4;
    localparam int ACK_TO_CYC  = 20;
    localparam int MAX_RETRY   = 2;
    localparam logic [7:0] DELAY_TAG = 8'hFF;
    localparam logic [7:0] END_TAG   = 8'hFE;

    typedef struct {
        int         cyc;
        logic [7:0] ab;
        logic [7:0] db;
    } pulse_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              init_done;
    logic              init_err;
    logic [ROM_AW-1:0] err_idx;

    iic_init_seq_if #(.ROM_AW(ROM_AW), .AB_W(8), .DB_W(8)) bus ();

    iic_init_seq #(
        .ROM_AW(ROM_AW), .NUM_ENTRIES(NUM_ENTRIES), .AB_W(8), .DB_W(8),
        .PWRUP_CYC(PWRUP_CYC), .GAP_CYC(GAP_CYC), .ACK_TO_CYC(ACK_TO_CYC),
        .MAX_RETRY(MAX_RETRY), .DELAY_TAG(DELAY_TAG), .END_TAG(END_TAG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .init_done(init_done), .init_err(init_err), .err_idx(err_idx)
    );

    logic [15:0] rom [0:127];
    int          resp_lat [64];
    bit          resp_nack [64];
    int          cyc;
    int          n_cmp;
    int          n_fail;
    bit          chk_on;

    pulse_t      exp_q [$];
    int          exp_end;
    bit          exp_err;
    int          exp_err_idx;
    int          exp_addr;
    int          exp_n;

    bit          have_last;
    pulse_t      last_p;
    int          seen_n;
    int          first_cyc;
    int          second_cyc;
    logic [7:0]  seen_ab [$];

    bit          m_pend;
    int          m_cyc;
    bit          m_nack;
    int          m_k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // Cycle 0 is the interval between reset release and the first rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Timeline model: each entry's write/ack/gap/delay is laid out in absolute cycles.
    task automatic build_model(input int base);
        int t, idx, k, tries, r, e, lat, w;
        logic [7:0] ab, db;
        bit fin, entry_done, resp_ok;
        exp_q.delete();
        t = base + PWRUP_CYC;
        idx = 0;
        k = 0;
        fin = 0;
        while (!fin) begin
            ab = rom[idx][15:8];
            db = rom[idx][7:0];
            if (ab == END_TAG) begin
                exp_end = t + 2; exp_err = 0; exp_addr = idx; fin = 1;
            end else begin
                if (ab == DELAY_TAG) begin
                    w = (db == 0) ? 1 : int'(db);
                    t = t + 2 + w * GAP_CYC;
                end else begin
                    r = t + 2;
                    tries = 0;
                    entry_done = 0;
                    while (!entry_done) begin
                        exp_q.push_back('{r, ab, db});
                        lat = resp_lat[k];
                        resp_ok = (lat >= 1) && (lat <= ACK_TO_CYC);
                        e = resp_ok ? r + lat : r + ACK_TO_CYC;
                        if (resp_ok && !resp_nack[k]) begin
                            t = e + 1 + GAP_CYC; entry_done = 1;
                        end else if (tries < MAX_RETRY) begin
                            tries++; r = e + 1 + GAP_CYC;
                        end else begin
                            exp_end = e + 1; exp_err = 1; exp_err_idx = idx; exp_addr = idx;
                            fin = 1; entry_done = 1;
                        end
                        k++;
                    end
                end
                if (!fin) begin
                    if (idx == NUM_ENTRIES - 1) begin
                        exp_end = t; exp_err = 0; exp_addr = idx; fin = 1;
                    end else begin
                        idx++;
                    end
                end
            end
        end
        exp_n = exp_q.size();
    endtask

    task automatic reset_stats();
        have_last  = 0;
        seen_n     = 0;
        first_cyc  = -1;
        second_cyc = -1;
        seen_ab.delete();
        m_k        = 0;
    endtask

    task automatic compare_cycle();
        bit exp_en;
        bit ended;
        exp_en = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        checkOutput("tiic_en", bus.tiic_en, exp_en);
        if (exp_en) begin
            last_p = exp_q.pop_front();
            have_last = 1;
        end
        if (bus.tiic_en === 1'b1) begin
            seen_n++;
            if (seen_n == 1) first_cyc = cyc;
            if (seen_n == 2) second_cyc = cyc;
            seen_ab.push_back(bus.tiic_ab);
        end
        if (have_last) begin
            checkOutput("tiic_ab", bus.tiic_ab, last_p.ab);
            checkOutput("tiic_db", bus.tiic_db, last_p.db);
        end
        ended = (cyc >= exp_end);
        checkOutput("busy", busy, !ended);
        checkOutput("init_done", init_done, ended && !exp_err);
        checkOutput("init_err", init_err, ended && exp_err);
        if (ended && exp_err) checkOutput("err_idx", err_idx, exp_err_idx);
    endtask

    // IIC master: answers the k-th request after resp_lat[k] cycles (0 = never answers).
    task automatic master_step();
        bus.iic_done = 1'b0;
        bus.iic_nack = 1'b0;
        if (rst) begin
            m_pend = 0;
        end else begin
            if (m_pend && (cyc == m_cyc)) begin
                bus.iic_done = 1'b1;
                bus.iic_nack = m_nack;
                m_pend = 0;
            end
            if (bus.tiic_en === 1'b1) begin
                if (resp_lat[m_k] > 0) begin
                    m_pend = 1;
                    m_cyc  = cyc + resp_lat[m_k];
                    m_nack = resp_nack[m_k];
                end
                m_k++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst && chk_on) compare_cycle();
        master_step();
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) tick();
        if (cyc < target) checkOutput("run_bound", 32'(cyc), 32'(target));
    endtask

    task automatic check_reset_state();
        #1;
        checkOutput("rst_rom_addr", bus.rom_addr, 0);
        checkOutput("rst_tiic_en", bus.tiic_en, 0);
        checkOutput("rst_tiic_ab", bus.tiic_ab, 0);
        checkOutput("rst_tiic_db", bus.tiic_db, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_init_err", init_err, 0);
        checkOutput("rst_err_idx", err_idx, 0);
    endtask

    task automatic begin_run();
        rst = 1'b1;
        chk_on = 0;
        tick();
        tick();
        check_reset_state();
        build_model(0);
        reset_stats();
        rst = 1'b0;
        chk_on = 1;
    endtask

    task automatic finish_run();
        run_until(exp_end + 10);
        checkOutput("final_rom_addr", bus.rom_addr, exp_addr);
        checkOutput("pulse_count", seen_n, exp_n);
        checkOutput("unseen_pulses", exp_q.size(), 0);
    endtask

    task automatic applyStimulus();
        begin_run();
        finish_run();
    endtask

    task automatic load_base_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1214;
        rom[1] = 16'h1101;
        rom[2] = 16'h2280;
        rom[3] = 16'h3344;
    endtask

    task automatic set_resp(input int lat);
        for (int k = 0; k < 64; k++) begin
            resp_lat[k]  = lat;
            resp_nack[k] = 0;
        end
    endtask

    function automatic int count_ab(input logic [7:0] ab);
        int n = 0;
        foreach (seen_ab[i]) if (seen_ab[i] == ab) n++;
        return n;
    endfunction

    initial begin
        n_cmp = 0;
        n_fail = 0;
        chk_on = 0;
        rst = 1'b1;
        start = 1'b0;
        m_pend = 0;
        load_base_rom();
        set_resp(3);

        $display("[TB] plain table, master acks after 3 cycles");
        applyStimulus();
        checkOutput("A_first_pulse_cyc", first_cyc, 12);
        checkOutput("A_pulses", seen_n, 4);
        checkOutput("A_ab0", seen_ab[0], 8'h12);
        checkOutput("A_ab1", seen_ab[1], 8'h11);
        checkOutput("A_ab2", seen_ab[2], 8'h22);
        checkOutput("A_ab3", seen_ab[3], 8'h33);
        checkOutput("A_init_done", init_done, 1);

        $display("[TB] delay entry");
        rom[1] = 16'hFF03;
        applyStimulus();
        checkOutput("B_pulses", seen_n, 3);
        checkOutput("B_second_pulse_cyc", second_cyc, 36);

        $display("[TB] end tag");
        load_base_rom();
        rom[2] = 16'hFE00;
        applyStimulus();
        checkOutput("C_pulses", seen_n, 2);
        checkOutput("C_rom_addr", bus.rom_addr, 2);
        checkOutput("C_init_done", init_done, 1);

        $display("[TB] entry1 nacked twice then acked");
        load_base_rom();
        resp_nack[1] = 1;
        resp_nack[2] = 1;
        applyStimulus();
        checkOutput("D_entry1_pulses", count_ab(8'h11), 3);
        checkOutput("D_init_done", init_done, 1);
        checkOutput("D_init_err", init_err, 0);

        $display("[TB] entry1 always nacked");
        set_resp(3);
        for (int k = 1; k < 4; k++) resp_nack[k] = 1;
        applyStimulus();
        checkOutput("E_entry1_pulses", count_ab(8'h11), 3);
        checkOutput("E_init_err", init_err, 1);
        checkOutput("E_err_idx", err_idx, 1);
        checkOutput("E_busy", busy, 0);

        $display("[TB] entry1 never answered");
        set_resp(3);
        for (int k = 1; k < 4; k++) resp_lat[k] = 0;
        applyStimulus();
        checkOutput("F_entry1_pulses", count_ab(8'h11), 3);
        checkOutput("F_init_err", init_err, 1);
        checkOutput("F_err_idx", err_idx, 1);

        $display("[TB] start during WAIT");
        set_resp(3);
        begin_run();
        run_until(13);
        start = 1'b1;
        build_model(14);
        reset_stats();
        tick();
        start = 1'b0;
        checkOutput("G_tiic_en_low", bus.tiic_en, 0);
        finish_run();
        checkOutput("G_first_pulse_cyc", first_cyc, 26);
        checkOutput("G_init_done", init_done, 1);

        $display("[TB] reset during GAP");
        begin_run();
        run_until(17);
        rst = 1'b1;
        chk_on = 0;
        #1;
        checkOutput("H_tiic_en_low", bus.tiic_en, 0);
        checkOutput("H_busy", busy, 1);
        checkOutput("H_rom_addr", bus.rom_addr, 0);
        tick();
        tick();
        build_model(0);
        reset_stats();
        rst = 1'b0;
        chk_on = 1;
        finish_run();
        checkOutput("H_first_pulse_cyc", first_cyc, 12);
        checkOutput("H_pulses", seen_n, 4);

        $display("[TB] randomized tables and master behaviour");
        for (int run = 0; run < 10; run++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                int sel;
                sel = $urandom_range(0, 9);
                if (sel == 0)               rom[i] = {DELAY_TAG, 8'($urandom_range(0, 3))};
                else if (sel == 1 && i > 0) rom[i] = {END_TAG, 8'($urandom)};
                else                        rom[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
            end
            for (int k = 0; k < 64; k++) begin
                resp_lat[k]  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 25));
                resp_nack[k] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
